// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point DIT FFT pipeline.
// Used by the input bit-reverse buffer, the output reorder stage and the
// twiddle sequencer so all stages agree on frame size and index order.
//   N      : points per frame
//   LOG2N  : address width of a frame
//   DATA_W : complex sample width, [31:16] real FP16, [15:0] imaginary FP16
//   bitrev3: 3-bit bit reversal of a sample index
//   S1_NUM1_IDX / S1_NUM2_IDX : stage-1 operand sample indices per pair
package fft8_pkg;

  localparam int N      = 8;
  localparam int LOG2N  = 3;
  localparam int DATA_W = 32;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

  // Element [p] is the sample index for pair p: (0,4) (2,6) (1,5) (3,7).
  localparam logic [3:0][LOG2N-1:0] S1_NUM1_IDX = {3'd3, 3'd1, 3'd2, 3'd0};
  localparam logic [3:0][LOG2N-1:0] S1_NUM2_IDX = {3'd7, 3'd5, 3'd6, 3'd4};

endpackage

// File: rtl/fft8_bank.sv
// One frame of storage: N x DATA_W registers.
// Ports:
//   clk            : rising-edge clock
//   we             : write enable for this bank
//   waddr, wdata   : write address (natural sample index) and data
//   raddr1, rdata1 : combinational read port 1
//   raddr2, rdata2 : combinational read port 2
// Sample data is not reset; the owner qualifies reads with its own flags.
module fft8_bank
  import fft8_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [LOG2N-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LOG2N-1:0]  raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [LOG2N-1:0]  raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/fft8_bitrev_buffer.sv
// Input reorder stage for the 8-point DIT FFT.
// Samples arrive in natural order and are written into one of two banks
// (ping-pong). A full bank is drained as four stage-1 butterfly operand
// pairs in bit-reversed order while the other bank fills.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_data/in_valid      : input sample stream, natural order
//   in_ready              : write bank has room
//   num1/num2             : upper/lower butterfly operands (0 when idle)
//   twiddle_index         : stage-1 twiddle, always 0
//   out_valid/out_ready   : operand pair handshake
//   out_pair/out_last     : pair number in frame, high on pair 3
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds data stable while valid && !ready, and
// valid never depends combinationally on ready.
module fft8_bitrev_buffer
  import fft8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output logic [2:0]        twiddle_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_pair,
  output logic              out_last
);

  localparam logic [LOG2N-1:0] LAST_SAMPLE = 3'(N - 1);
  localparam logic [1:0]       LAST_PAIR   = 2'd3;

  logic [1:0]       full_q, full_nxt;
  logic             wr_bank_q, rd_bank_q;
  logic [LOG2N-1:0] wr_cnt_q;
  logic [1:0]       rd_pair_q;

  logic             wr_fire, rd_fire;
  logic             wr_frame_done, rd_frame_done;
  logic [LOG2N-1:0] rd_addr1, rd_addr2;
  logic [DATA_W-1:0] b0_rd1, b0_rd2, b1_rd1, b1_rd2;

  // Both handshake outputs decode flops only, so there is no path from
  // out_ready to out_valid or from in_valid to in_ready.
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];

  assign wr_fire       = in_valid && in_ready;
  assign rd_fire       = out_valid && out_ready;
  assign wr_frame_done = wr_fire && (wr_cnt_q == LAST_SAMPLE);
  assign rd_frame_done = rd_fire && (rd_pair_q == LAST_PAIR);

  // A write only targets a non-full bank and a read only drains a full one,
  // so the set and the clear below always hit different bits.
  always_comb begin
    full_nxt = full_q;
    if (wr_frame_done) full_nxt[wr_bank_q] = 1'b1;
    if (rd_frame_done) full_nxt[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_pair_q <= '0;
    end else begin
      full_q <= full_nxt;
      if (wr_fire) begin
        wr_cnt_q <= wr_cnt_q + 3'd1;  // wraps 7 -> 0 naturally
        if (wr_frame_done) wr_bank_q <= ~wr_bank_q;
      end
      if (rd_fire) begin
        rd_pair_q <= rd_pair_q + 2'd1;  // wraps 3 -> 0 naturally
        if (rd_frame_done) rd_bank_q <= ~rd_bank_q;
      end
    end
  end

  // Pair p reads samples bitrev(2p) and bitrev(2p+1).
  assign rd_addr1 = bitrev3({rd_pair_q, 1'b0});
  assign rd_addr2 = bitrev3({rd_pair_q, 1'b1});

  fft8_bank u_bank0 (
    .clk    (clk),
    .we     (wr_fire && !wr_bank_q),
    .waddr  (wr_cnt_q),
    .wdata  (in_data),
    .raddr1 (rd_addr1),
    .rdata1 (b0_rd1),
    .raddr2 (rd_addr2),
    .rdata2 (b0_rd2)
  );

  fft8_bank u_bank1 (
    .clk    (clk),
    .we     (wr_fire && wr_bank_q),
    .waddr  (wr_cnt_q),
    .wdata  (in_data),
    .raddr1 (rd_addr1),
    .rdata1 (b1_rd1),
    .raddr2 (rd_addr2),
    .rdata2 (b1_rd2)
  );

  // The read bank is never written while full, so the operands stay stable
  // under backpressure. Zeroing when idle hides unreset bank contents.
  assign num1 = out_valid ? (rd_bank_q ? b1_rd1 : b0_rd1) : '0;
  assign num2 = out_valid ? (rd_bank_q ? b1_rd2 : b0_rd2) : '0;

  assign out_pair      = rd_pair_q;
  assign out_last      = out_valid && (rd_pair_q == LAST_PAIR);
  assign twiddle_index = 3'b000;

endmodule

// File: tb/tb_fft8_bitrev_buffer.sv
// Self-checking bench for fft8_bitrev_buffer: a frame-queue model predicts
// in_ready and every output pair; directed phases pin the model with
// hand-computed values.
module tb_fft8_bitrev_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] num1, num2;
  logic [2:0]  twiddle_index;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_pair;
  logic        out_last;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  fft8_bitrev_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .num1          (num1),
    .num2          (num2),
    .twiddle_index (twiddle_index),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pair      (out_pair),
    .out_last      (out_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds complete frames (8 words each) in arrival order; the front
  // frame is the one being read. part_q collects the frame being written.
  logic [31:0] exp_q[$];
  logic [31:0] part_q[$];
  int          m_pair = 0;
  bit          acc_flag = 1'b0;
  // Bit-reversed read order: pair p uses br[2p] and br[2p+1].
  int          br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic int frames_held();
    return exp_q.size() / 8;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      part_q.delete();
      m_pair   = 0;
      acc_flag = 1'b0;
    end else begin
      bit rdy, vld;
      rdy = frames_held() < 2;
      vld = frames_held() >= 1;
      acc_flag = in_valid && rdy;
      if (vld && out_ready) begin
        if (m_pair == 3) begin
          repeat (8) void'(exp_q.pop_front());
          m_pair = 0;
        end else begin
          m_pair++;
        end
      end
      if (acc_flag) begin
        part_q.push_back(in_data);
        if (part_q.size() == 8) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
        end
      end
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst num1", num1, 32'd0);
      chk("rst num2", num2, 32'd0);
      chk("rst out_pair", 32'(out_pair), 32'd0);
      chk("rst out_last", 32'(out_last), 32'd0);
      chk("rst twiddle", 32'(twiddle_index), 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(frames_held() < 2));
      chk("out_valid", 32'(out_valid), 32'(frames_held() >= 1));
      chk("twiddle", 32'(twiddle_index), 32'd0);
      if (frames_held() >= 1) begin
        chk("num1", num1, exp_q[br[2*m_pair]]);
        chk("num2", num2, exp_q[br[2*m_pair+1]]);
        chk("out_pair", 32'(out_pair), 32'(m_pair));
        chk("out_last", 32'(out_last), 32'(m_pair == 3));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one sample and holds it until the handshake completes;
  // returns #1 after the accepting edge with the number of extra cycles.
  task automatic drive_sample(input logic [31:0] d, output int stalls);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(posedge clk); #1;
      if (acc_flag) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL drive timeout: sample %h not accepted in 200 cycles", d);
        break;
      end
    end
    in_valid = 1'b0;
    stalls = n;
  endtask

  task automatic send_frame(input logic [31:0] f [8], output int stalls);
    int s, tot = 0;
    for (int i = 0; i < 8; i++) begin
      drive_sample(f[i], s);
      tot += s;
    end
    stalls = tot;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_pair(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                          input int p);
    chk({tag, " num1"}, num1, e1);
    chk({tag, " num2"}, num2, e2);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " pair"}, 32'(out_pair), 32'(p));
    chk({tag, " last"}, 32'(out_last), 32'(p == 3));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] frame_a [8] = '{32'h00000000, 32'h3c000000, 32'h40000000, 32'h42000000,
                                32'h44000000, 32'h45000000, 32'h46000000, 32'h47000000};
  logic [31:0] frame_i [8];
  logic [31:0] frame_r [8];

  initial begin
    int st;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Single frame, out_ready high: pairs (0,4) (2,6) (1,5) (3,7).
    out_ready = 1'b1;
    send_frame(frame_a, st);
    @(negedge clk); chk_pair("lit p0", 32'h00000000, 32'h44000000, 0);
    @(negedge clk); chk_pair("lit p1", 32'h40000000, 32'h46000000, 1);
    @(negedge clk); chk_pair("lit p2", 32'h3c000000, 32'h45000000, 2);
    @(negedge clk); chk_pair("lit p3", 32'h42000000, 32'h47000000, 3);
    @(negedge clk); chk("lit drained valid", 32'(out_valid), 32'd0);
    idle(3);

    // Backpressure at pair 1 for 5 cycles.
    send_frame(frame_a, st);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk); chk_pair("hold p1", 32'h40000000, 32'h46000000, 1);
    end
    #1 out_ready = 1'b1;
    idle(6);

    // Both banks full.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) drive_sample($urandom, st);
    @(negedge clk); chk("both full in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 32'hdeadbeef;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("17th ignored", 32'(acc_flag), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("full wait in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); chk("freed in_ready", 32'(in_ready), 32'd1);
    idle(8);

    // Streaming: 4 back-to-back frames, in_ready must never drop.
    begin
      int tot = 0;
      for (int f = 0; f < 4; f++) begin
        foreach (frame_r[i]) frame_r[i] = $urandom;
        send_frame(frame_r, st);
        tot += st;
      end
      chk("stream stalls", 32'(tot), 32'd0);
    end
    idle(8);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idle(12);
    // Finish any partial frame so the model and DUT start aligned.
    while (part_q.size() != 0) drive_sample($urandom, st);
    idle(8);

    // Reset mid-operation while frame 0 waits and frame 1 is partial.
    out_ready = 1'b0;
    foreach (frame_r[i]) frame_r[i] = $urandom;
    send_frame(frame_r, st);
    for (int i = 0; i < 5; i++) drive_sample($urandom, st);
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    chk("post rst out_valid", 32'(out_valid), 32'd0);

    // Fresh frame with imaginary-only content.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) frame_i[i] = 32'h0000_0010 + 32'(i);
    send_frame(frame_i, st);
    @(negedge clk); chk_pair("imag p0", 32'h00000010, 32'h00000014, 0);
    @(negedge clk); chk_pair("imag p1", 32'h00000012, 32'h00000016, 1);
    @(negedge clk); chk_pair("imag p2", 32'h00000011, 32'h00000015, 2);
    @(negedge clk); chk_pair("imag p3", 32'h00000013, 32'h00000017, 3);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft8_bitrev_buffer.md
Name: fft8_bitrev_buffer

Overview:
Input reorder stage placed directly upstream of butterfly2p in the 8-point DIT FFT.
- Accepts complex samples one per cycle in natural order 0..7.
- Stores each frame in one bank of a two-bank ping-pong buffer.
- Presents the frame to butterfly2p as four stage-1 operand pairs (num1, num2) in bit-reversed order, so one bank can fill while the other drains.

Parameters:
N, 8, FFT points per frame; fixed at 8 for this block, with LOG2N=3 as a derived localparam.
DATA_W, 32, complex sample width: [31:16] real FP16, [15:0] imaginary FP16. Data passes through unmodified.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  DATA_W  input sample, natural order
in_valid  in  1  in_data valid
in_ready  out  1  buffer can accept a sample
num1  out  DATA_W  upper butterfly operand
num2  out  DATA_W  lower butterfly operand
twiddle_index  out  3  stage-1 twiddle, constant 3'b000
out_valid  out  1  num1/num2 valid
out_ready  in  1  downstream accepts pair
out_pair  out  2  pair index within frame, 0..3
out_last  out  1  high with pair 3

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset state:
  - both bank-full flags = 0; wr_bank = rd_bank = 0; wr_cnt = 0; rd_pair = 0.
  - num1 = num2 = 0; out_valid = 0; out_pair = 0; out_last = 0; twiddle_index = 0.
  - in_ready = 1 from the first edge after deassertion.
- Reset mid-frame discards partial and full frames; no output pair is emitted after reset until a complete new frame is written.
- Write side:
  - A sample is accepted on a clk edge with in_valid && in_ready.
  - Stored to mem[wr_bank][wr_cnt]; wr_cnt increments.
  - On the sample with wr_cnt = 7: full[wr_bank] is set, wr_bank toggles, wr_cnt wraps to 0.
  - in_ready = !full[wr_bank], registered.
- Read side:
  - out_valid = full[rd_bank], registered, with no combinational path from out_ready.
  - Pair p (= rd_pair) outputs num1 = mem[rd_bank][bitrev3(2p)] and num2 = mem[rd_bank][bitrev3(2p+1)].
  - Resulting index pairs: (0,4), (2,6), (1,5), (3,7).
  - out_pair = p; out_last = (p == 3) && out_valid.
  - A pair is consumed with out_valid && out_ready; rd_pair then increments.
  - On consumption of pair 3: full[rd_bank] clears, rd_bank toggles, rd_pair wraps to 0.
  - num1/num2/out_pair hold stable while out_valid && !out_ready.
- Latency: out_valid rises on the edge that accepts sample 7 and is visible in the following cycle. The first pair is available 1 cycle after the last sample is accepted.
- Throughput: 8 input cycles per frame against 4 output cycles, so continuous streaming sustains in_ready = 1 when out_ready = 1.
- Both banks full: in_ready = 0. It rises the cycle after pair 3 of the read bank is consumed, because the freed bank is the current wr_bank.
- Simultaneous write of sample 7 into one bank and consumption of pair 3 from the other: both flag updates apply on the same edge with no conflict.
- in_valid while in_ready = 0: the sample is ignored; the upstream stage must hold it.
- twiddle_index is tied to 0 for all stage-1 pairs. Later stages use their own twiddle sequencing.

Decomposition:
- Shared package fft8_pkg holds:
  - localparams N = 8, LOG2N = 3, DATA_W = 32
  - bitrev3 function
  - pair index table localparams for stage 1
- Package reuse: the output reorder and twiddle sequencer stages use the same package.
- Sub-module: fft8_bank, one N x DATA_W register bank with a write port and two combinational read ports. It is instantiated twice.
- Control (flags, counters, bank selects) stays in the top.

Test Plan:
- Single frame, real parts 0..7 (in_data = 0x00000000, 0x3c000000, 0x40000000, 0x42000000, 0x44000000, 0x45000000, 0x46000000, 0x47000000), out_ready = 1 -> pairs:
  - (0x00000000, 0x44000000)
  - (0x40000000, 0x46000000)
  - (0x3c000000, 0x45000000)
  - (0x42000000, 0x47000000)
  - out_pair 0..3; out_last on pair 3; twiddle_index = 0.
- Backpressure: out_ready = 0 for 5 cycles at pair 1 -> num1/num2 hold at 0x40000000/0x46000000 and out_valid stays 1; no pair is skipped or duplicated.
- Both banks full: write 16 samples with out_ready = 0 -> in_ready = 0 after the 16th sample; a 17th in_valid is not accepted. in_ready returns 1 the cycle after pair 3 of frame 0 is consumed.
- Streaming: 4 back-to-back frames with in_valid = out_ready = 1 -> in_ready never drops; 16 pairs come out in frame order with correct bit-reversed content.
- Reset mid-operation: assert rst_n = 0 after 5 samples of frame 1 while frame 0 is draining -> out_valid = 0 and in_ready = 1 immediately. The next 8 samples form a fresh frame, and its first pair is (sample 0, sample 4).
- Imaginary path: samples with imaginary part k (0x0000_xxxx) -> the imaginary halves appear in the same bit-reversed pairing as the real halves.
